unidade_busca: RTL and testbench
================================

// Module: unidade_busca
// PURPOSE
//  Instruction fetch unit: the initiator side of the instruction-memory read port.
//  - Owns the program counter and drives `endereco`.
//  - Captures `instrucao`, which memory updates on negedge.
//  - Hands {pc, instr} to the decoder over a valid/ready handshake through a small
//    skid FIFO.
//  - Accepts branch/jump redirects from the execute stage.
// PARAMETERS
//  ADDR_W    8      width of endereco / PC
//  DATA_W    8      width of instrucao
//  RESET_PC  8'd10  first address fetched after reset
//  DEPTH     2      skid FIFO entries (power of 2, >=2)
// PORTS
//  clock          in   1       single clock; all state on posedge
//  reset_n        in   1       asynchronous, active-low reset
//  endereco       out  ADDR_W  address to instruction memory (registered)
//  instrucao      in   DATA_W  memory data for endereco, valid by next posedge
//  habilita       in   1       1 = issue new fetches; 0 = stop issuing (in-flight completes)
//  desvio_valido  in   1       redirect request, single-cycle pulse
//  desvio_alvo    in   ADDR_W  redirect target PC
//  instr_valid    out  1       FIFO head valid
//  instr_ready    in   1       decoder accepts head
//  instr_out      out  DATA_W  head instruction
//  instr_pc       out  ADDR_W  PC of head instruction
// BEHAVIOUR
//  Reset values:
//  - endereco=RESET_PC, pc_next=RESET_PC, req_v=0, FIFO empty
//  - instr_valid=0, instr_out=0, instr_pc=0
//  Timing:
//  - endereco changes only on posedge, so it is stable across the memory's negedge.
//  - Latency: address issued at posedge N -> instrucao captured at posedge N+1 ->
//    instr_valid high after N+1.
//  Pop: instr_valid & instr_ready at posedge removes head.
//  Push (at a posedge, unless desvio_valido that cycle):
//  - If req_v, write {pc=endereco, instr=instrucao} into FIFO.
//  Issue (at a posedge):
//  - Condition: habilita & (count_after_push_pop + issue) <= DEPTH. Credit rule;
//    the FIFO can never overflow.
//  - Action: endereco<=pc_next, pc_next<=pc_next+1, req_v<=1.
//  - Otherwise: req_v<=0 and endereco holds.
//  - Sustained throughput: 1 instr/cycle while instr_ready=1.
//  Redirect (desvio_valido=1; highest priority):
//  - Flush FIFO; discard in-flight data (no push).
//  - endereco<=desvio_alvo, pc_next<=desvio_alvo+1, req_v<=1. Issues even if
//    habilita=0.
//  - instr_valid=0 the following cycle; the target instr is valid one cycle later.
//  - A pop in the same cycle as a redirect still counts as consumed.
//  PC arithmetic: modulo 2^ADDR_W (8'hFF+1 = 8'h00); no fault on wrap.
//  habilita low: no new issue; an in-flight request is still pushed; FIFO drains normally.
//  Async reset mid-operation:
//  - Outputs take reset values immediately; all in-flight/FIFO data is lost.
//  - Fetch restarts at RESET_PC on the first posedge after reset_n rises.
//  Payload stability: instr_out/instr_pc must not change while instr_valid & !instr_ready.
// STRUCTURE
//  Package pacote_busca:
//  - ADDR_W, DATA_W, RESET_PC constants
//  - typedef struct packed {logic [ADDR_W-1:0] pc; logic [DATA_W-1:0] instr;}
//    entrada_busca_t
//  Sub-module fila_busca:
//  - DEPTH-entry FIFO of entrada_busca_t with push/pop/flush and count.
//  - Head read combinationally from registered storage.
//  Top: PC/credit logic, redirect priority, req_v tracking.
// TESTING (bench instantiates instructions memory preloaded at 10..27)
//  1. Reset release, habilita=1, ready=1:
//     endereco 10,11,12,... one per cycle; out (10,07),(11,02),(12,01),(13,1E),
//     first valid 2 posedges after reset release.
//  2. ready=0 for 6 cycles mid-stream:
//     count<=2, endereco frozen, then resumes; stream order gap-free, no duplicates.
//  3. FIFO full, pulse redirect alvo=22:
//     stale entries flushed; next valid (22,09) then (23,0F); instr_valid=0 exactly
//     one cycle.
//  4. Redirect alvo=8'hFE:
//     instr_pc sequence FE,FF,00,01 (wrap, no hang).
//  5. Mid-stream reset_n low between edges:
//     instr_valid=0, endereco=10 immediately; after release stream restarts at (10,07).
//  6. Redirect coincident with a pop and habilita=0:
//     popped entry delivered once; target fetched; then no further issue until
//     habilita=1.

Source files
------------

// File: rtl/unidade_busca_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : pacote_busca                                                 |
// | Purpose   : Shared widths, reset PC and FIFO entry type for the          |
// |             instruction fetch unit.                                      |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package pacote_busca;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam logic [ADDR_W-1:0] RESET_PC = 8'd10;

   // One fetched instruction together with the address it came from.
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } entrada_busca_t;

   // The PC wraps at 2^ADDR_W; the carry is simply dropped.
   function automatic logic [ADDR_W-1:0] pc_mais_um(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fila_busca.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : fila_busca                                                   |
// | Purpose   : Small skid FIFO of fetched {pc, instr} entries with push,    |
// |             pop, synchronous flush and occupancy count. Head is read     |
// |             combinationally from registered storage.                     |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module fila_busca
   import pacote_busca::*;
#(
   parameter int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  entrada_busca_t   dado_in,
   output entrada_busca_t   cabeca,
   output logic             vazia,
   output logic [CNT_W-1:0] contagem
);

   entrada_busca_t   armazenamento [DEPTH];
   logic [PTR_W-1:0] ptr_escrita;
   logic [PTR_W-1:0] ptr_leitura;
   logic             faz_push;
   logic             faz_pop;
   logic             cheia;

   // Qualified handshakes: never pop an empty FIFO, never overwrite a full one
   // unless the head leaves in the same cycle.
   always_comb begin
      vazia    = (contagem == '0);
      cheia    = (contagem == CNT_W'(DEPTH));
      faz_pop  = pop & ~vazia;
      faz_push = push & (~cheia | faz_pop);
   end

   // Storage needs no reset: the head is only meaningful while not empty.
   always_ff @(posedge clock) begin
      if (faz_push && !flush) begin
         armazenamento[ptr_escrita] <= dado_in;
      end
   end

   // Pointers and count; flush wins over any simultaneous push or pop.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_escrita <= '0;
         ptr_leitura <= '0;
         contagem    <= '0;
      end else if (flush) begin
         ptr_escrita <= '0;
         ptr_leitura <= '0;
         contagem    <= '0;
      end else begin
         if (faz_push) begin
            ptr_escrita <= ptr_escrita + PTR_W'(1);
         end
         if (faz_pop) begin
            ptr_leitura <= ptr_leitura + PTR_W'(1);
         end
         contagem <= contagem + CNT_W'(faz_push) - CNT_W'(faz_pop);
      end
   end

   assign cabeca = armazenamento[ptr_leitura];

endmodule
`default_nettype wire

// File: rtl/unidade_busca.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : unidade_busca                                                |
// | Purpose   : Instruction fetch unit. Owns the PC, drives the registered   |
// |             memory address, captures returned instructions into a skid   |
// |             FIFO and presents them to the decoder over valid/ready.      |
// |             Redirects from execute flush the pipe and restart fetch.     |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module unidade_busca
   import pacote_busca::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   output logic [ADDR_W-1:0] endereco,
   input  logic [DATA_W-1:0] instrucao,
   input  logic              habilita,
   input  logic              desvio_valido,
   input  logic [ADDR_W-1:0] desvio_alvo,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] instr_pc
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] pc_next;
   logic              req_v;
   logic              pop;
   logic              push;
   logic              emite;
   logic              vazia;
   logic [CNT_W-1:0]  contagem;
   logic [CNT_W-1:0]  contagem_pos;
   entrada_busca_t    entrada;
   entrada_busca_t    cabeca;

   // Credit check: a new request is only issued if its data is guaranteed a
   // slot when it returns next cycle, counting this cycle's push and pop.
   always_comb begin
      pop          = instr_valid & instr_ready;
      push         = req_v & ~desvio_valido;
      contagem_pos = contagem + CNT_W'(push) - CNT_W'(pop);
      emite        = habilita & (contagem_pos < CNT_W'(DEPTH));
      entrada.pc    = endereco;
      entrada.instr = instrucao;
   end

   // PC / address / in-flight tracking; a redirect overrides everything and
   // issues the target even when fetch is disabled.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         endereco <= RESET_PC;
         pc_next  <= RESET_PC;
         req_v    <= 1'b0;
      end else if (desvio_valido) begin
         endereco <= desvio_alvo;
         pc_next  <= pc_mais_um(desvio_alvo);
         req_v    <= 1'b1;
      end else if (emite) begin
         endereco <= pc_next;
         pc_next  <= pc_mais_um(pc_next);
         req_v    <= 1'b1;
      end else begin
         req_v    <= 1'b0;
      end
   end

   fila_busca #(
      .DEPTH    (DEPTH)
   ) u_fila (
      .clock    (clock),
      .reset_n  (reset_n),
      .push     (push),
      .pop      (pop),
      .flush    (desvio_valido),
      .dado_in  (entrada),
      .cabeca   (cabeca),
      .vazia    (vazia),
      .contagem (contagem)
   );

   // Payload is forced to zero while empty so stale storage never leaks out.
   always_comb begin
      instr_valid = ~vazia;
      instr_out   = instr_valid ? cabeca.instr : '0;
      instr_pc    = instr_valid ? cabeca.pc    : '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_unidade_busca.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_unidade_busca                                             |
// | Purpose   : Self-checking bench for unidade_busca with a negedge         |
// |             instruction memory and a stream-order reference model.       |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_unidade_busca;
   import pacote_busca::*;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic [ADDR_W-1:0] endereco;
   logic [DATA_W-1:0] instrucao;
   logic              habilita = 1'b0;
   logic              desvio_valido = 1'b0;
   logic [ADDR_W-1:0] desvio_alvo = '0;
   logic              instr_valid;
   logic              instr_ready = 1'b0;
   logic [DATA_W-1:0] instr_out;
   logic [ADDR_W-1:0] instr_pc;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: the decoder must see consecutive PCs, restarting at the
   // redirect target, each carrying the memory word at that PC.
   logic [7:0] mem [0:255];
   logic [7:0] exp_pc;
   logic [7:0] hs_log [$];
   logic       prev_stall = 1'b0;
   logic       prev_desvio = 1'b0;
   logic [7:0] prev_pc;
   logic [7:0] prev_instr;
   logic [7:0] e_ref;

   unidade_busca #(.DEPTH(2)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .endereco      (endereco),
      .instrucao     (instrucao),
      .habilita      (habilita),
      .desvio_valido (desvio_valido),
      .desvio_alvo   (desvio_alvo),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr_out     (instr_out),
      .instr_pc      (instr_pc)
   );

   always #5 clock = ~clock;

   // Instruction memory updates its data on the falling edge.
   always @(negedge clock) instrucao <= mem[endereco];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample outputs at negedge, score handshakes, then return
   // 1 time unit after the next posedge so the caller can drive inputs.
   task automatic tick();
      @(negedge clock);
      if (prev_desvio) check("redirect_bubble", instr_valid, 1'b0);
      if (prev_stall) begin
         check("stable_pc", instr_pc, prev_pc);
         check("stable_instr", instr_out, prev_instr);
      end
      if (instr_valid && instr_ready) begin
         check("order_pc", instr_pc, exp_pc);
         check("order_instr", instr_out, mem[exp_pc]);
         hs_log.push_back(instr_pc);
         exp_pc = exp_pc + 8'd1;
      end
      if (desvio_valido) exp_pc = desvio_alvo;
      prev_desvio = desvio_valido;
      prev_stall  = instr_valid && !instr_ready && !desvio_valido;
      prev_pc     = instr_pc;
      prev_instr  = instr_out;
      @(posedge clock);
      #1;
   endtask

   task automatic wait_valid(input int budget, input string tag);
      int n = 0;
      while (!instr_valid && n < budget) begin
         tick();
         n++;
      end
      check(tag, instr_valid, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 5);
      mem[10] = 8'h07; mem[11] = 8'h02; mem[12] = 8'h01; mem[13] = 8'h1E;
      mem[22] = 8'h09; mem[23] = 8'h0F;

      // ---- 1. reset values and start-up stream ----
      habilita = 1'b1;
      instr_ready = 1'b1;
      #12;
      check("rst_valid", instr_valid, 1'b0);
      check("rst_out", instr_out, 8'h00);
      check("rst_pc", instr_pc, 8'h00);
      check("rst_endereco", endereco, 8'd10);
      #5 reset_n = 1'b1;
      exp_pc = 8'd10;
      tick();
      check("start_endereco0", endereco, 8'd10);
      check("start_valid0", instr_valid, 1'b0);
      tick();
      check("start_valid1", instr_valid, 1'b1);
      check("start_pc1", instr_pc, 8'd10);
      check("start_instr1", instr_out, 8'h07);
      check("start_endereco1", endereco, 8'd11);
      for (int i = 0; i < 4; i++) begin
         e_ref = endereco;
         tick();
         check("thru_valid", instr_valid, 1'b1);
         check("thru_endereco", endereco, e_ref + 8'd1);
      end

      // ---- 2. decoder stall for 6 cycles ----
      instr_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("stall_valid", instr_valid, 1'b1);
         if (i == 2) e_ref = endereco;
         if (i > 2) check("stall_endereco_frozen", endereco, e_ref);
      end
      instr_ready = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      check("resume_endereco", endereco, e_ref + 8'd1 + 8'd7);

      // ---- 3. redirect with FIFO full ----
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      desvio_valido = 1'b1;
      desvio_alvo = 8'd22;
      tick();
      desvio_valido = 1'b0;
      check("flush_valid", instr_valid, 1'b0);
      instr_ready = 1'b1;
      tick();
      check("tgt_valid", instr_valid, 1'b1);
      check("tgt_pc", instr_pc, 8'd22);
      check("tgt_instr", instr_out, 8'h09);
      tick();
      check("tgt_pc2", instr_pc, 8'd23);
      check("tgt_instr2", instr_out, 8'h0F);

      // ---- 4. redirect near the top of the address space ----
      desvio_valido = 1'b1;
      desvio_alvo = 8'hFE;
      tick();
      desvio_valido = 1'b0;
      hs_log.delete();
      for (int i = 0; i < 6; i++) tick();
      check("wrap_count", (hs_log.size() >= 4), 1'b1);
      if (hs_log.size() >= 4) begin
         check("wrap_pc0", hs_log[0], 8'hFE);
         check("wrap_pc1", hs_log[1], 8'hFF);
         check("wrap_pc2", hs_log[2], 8'h00);
         check("wrap_pc3", hs_log[3], 8'h01);
      end

      // ---- 5. asynchronous reset between edges ----
      #3 reset_n = 1'b0;
      #1;
      check("arst_valid", instr_valid, 1'b0);
      check("arst_endereco", endereco, 8'd10);
      check("arst_out", instr_out, 8'h00);
      check("arst_pc", instr_pc, 8'h00);
      @(posedge clock);
      #2 reset_n = 1'b1;
      exp_pc = 8'd10;
      prev_stall = 1'b0;
      prev_desvio = 1'b0;
      wait_valid(5, "arst_restart_valid");
      check("arst_restart_pc", instr_pc, 8'd10);
      check("arst_restart_instr", instr_out, 8'h07);
      for (int i = 0; i < 3; i++) tick();

      // ---- 6. redirect coincident with pop, fetch disabled ----
      check("coinc_pre_valid", instr_valid, 1'b1);
      habilita = 1'b0;
      desvio_valido = 1'b1;
      desvio_alvo = 8'd15;
      hs_log.delete();
      tick();
      desvio_valido = 1'b0;
      check("coinc_popped_once", hs_log.size(), 1);
      hs_log.delete();
      for (int i = 0; i < 6; i++) tick();
      check("coinc_tgt_count", hs_log.size(), 1);
      if (hs_log.size() >= 1) check("coinc_tgt_pc", hs_log[0], 8'd15);
      check("coinc_idle_valid", instr_valid, 1'b0);
      check("coinc_idle_endereco", endereco, 8'd15);
      habilita = 1'b1;
      wait_valid(5, "coinc_resume_valid");
      check("coinc_resume_pc", instr_pc, 8'd16);
      tick();

      // ---- randomized traffic against the stream model ----
      hs_log.delete();
      for (int i = 0; i < 1500; i++) begin
         instr_ready   = ($urandom_range(0, 3) != 0);
         habilita      = ($urandom_range(0, 7) != 0);
         desvio_valido = ($urandom_range(0, 31) == 0);
         desvio_alvo   = 8'($urandom);
         tick();
      end
      desvio_valido = 1'b0;
      habilita = 1'b1;
      instr_ready = 1'b1;
      check("rand_progress", (hs_log.size() > 100), 1'b1);
      wait_valid(10, "rand_liveness");
      for (int i = 0; i < 4; i++) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
